// File: rtl/snake_game_master.sv
// snake_game_master: top-level sequencer for the snake game.
// Owns the IDLE/PLAY/WIN(/PAUSE) state, the game tick and the heading.
// Ports:
//   CLK, RESET (async, active low)
//   BTN_U/D/L/R direction buttons, BTN_C pause button (SNAKE_PAUSE_EN)
//   REACHED_TARGET   head-on-apple level from the snake datapath
//   MASTER_STATE     0=IDLE 1=PLAY 2=WIN 3=PAUSE
//   NAVIGATION_STATE 00=right 01=down 10=up 11=left
//   GAMECLOCK        one-cycle tick pulse, PLAY only
//   SCORE            apples eaten, saturating at 15
//   APPLE_RELOAD     one-cycle request for a new apple position
// Optional feature macro: SNAKE_PAUSE_EN (BTN_C toggles PLAY/PAUSE).
module snake_game_master #(
  parameter int unsigned BASE_PERIOD  = 32'd5000000,
  parameter int unsigned SPEEDUP_STEP = 32'd250000,
  parameter int unsigned MIN_PERIOD   = 32'd1500000,
  parameter int unsigned WIN_SCORE    = 32'd10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_U,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       BTN_R,
  input  logic       BTN_C,
  input  logic       REACHED_TARGET,
  output logic [1:0] MASTER_STATE,
  output logic [1:0] NAVIGATION_STATE,
  output logic       GAMECLOCK,
  output logic [3:0] SCORE,
  output logic       APPLE_RELOAD
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_WIN   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  localparam logic [1:0] DIR_R = 2'b00;
  localparam logic [1:0] DIR_D = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_L = 2'b11;

  // ------------------------------------------------------------
  // Input synchronisers and rising-edge detectors
  // bit order: [5]=C (pause builds only), [4]=U, [3]=D,
  //            [2]=L, [1]=R, [0]=REACHED_TARGET
  // ------------------------------------------------------------
`ifdef SNAKE_PAUSE_EN
  localparam int NI = 6;
`else
  localparam int NI = 5;
`endif

  logic [NI-1:0] raw;
  logic [NI-1:0] sync1_q;
  logic [NI-1:0] sync2_q;
  logic [NI-1:0] edge_q;
  logic [NI-1:0] pulse;

`ifdef SNAKE_PAUSE_EN
  assign raw = {BTN_C, BTN_U, BTN_D, BTN_L, BTN_R, REACHED_TARGET};
`else
  assign raw = {BTN_U, BTN_D, BTN_L, BTN_R, REACHED_TARGET};
  logic unused_btn_c;
  assign unused_btn_c = BTN_C;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~edge_q;

  logic p_t;
  logic p_r;
  logic p_l;
  logic p_d;
  logic p_u;
  logic any_dir;

  assign p_t     = pulse[0];
  assign p_r     = pulse[1];
  assign p_l     = pulse[2];
  assign p_d     = pulse[3];
  assign p_u     = pulse[4];
  assign any_dir = p_u | p_d | p_l | p_r;

`ifdef SNAKE_PAUSE_EN
  logic p_c;
  assign p_c = pulse[5];
`endif

  // ------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  nav_q, nav_d;
  logic [1:0]  pend_q, pend_d;
  logic [3:0]  score_q, score_d;
  logic        gclk_q, gclk_d;
  logic        reload_q, reload_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      nav_q    <= DIR_R;
      pend_q   <= DIR_R;
      score_q  <= '0;
      gclk_q   <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nav_q    <= nav_d;
      pend_q   <= pend_d;
      score_q  <= score_d;
      gclk_q   <= gclk_d;
      reload_q <= reload_d;
    end
  end

  // ------------------------------------------------------------
  // Tick period: max(BASE - score*STEP, MIN) without underflow
  // ------------------------------------------------------------
  logic [31:0] dec;
  logic [31:0] period;
  logic        tick;

  always_comb begin
    dec = {28'd0, score_q} * SPEEDUP_STEP;
    if (dec >= BASE_PERIOD) begin
      period = MIN_PERIOD;
    end else if (BASE_PERIOD - dec < MIN_PERIOD) begin
      period = MIN_PERIOD;
    end else begin
      period = BASE_PERIOD - dec;
    end
  end

  // >= so a period that shrank below the count still fires next cycle
  assign tick = (cnt_q >= period - 32'd1);

  // ------------------------------------------------------------
  // Direction request: reversals of the committed heading are
  // dropped before priority, so a lower-priority legal press wins
  // ------------------------------------------------------------
  logic       ok_u;
  logic       ok_d;
  logic       ok_l;
  logic       ok_r;
  logic       dir_vld;
  logic [1:0] dir_sel;

  assign ok_u = p_u && (nav_q != DIR_D);
  assign ok_d = p_d && (nav_q != DIR_U);
  assign ok_l = p_l && (nav_q != DIR_R);
  assign ok_r = p_r && (nav_q != DIR_L);

  always_comb begin
    dir_vld = 1'b1;
    dir_sel = DIR_R;
    priority case (1'b1)
      ok_u:    dir_sel = DIR_U;
      ok_d:    dir_sel = DIR_D;
      ok_l:    dir_sel = DIR_L;
      ok_r:    dir_sel = DIR_R;
      default: dir_vld = 1'b0;
    endcase
  end

  logic [3:0] score_inc;
  assign score_inc = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;

  // ------------------------------------------------------------
  // Master FSM
  // ------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nav_d    = nav_q;
    pend_d   = pend_q;
    score_d  = score_q;
    gclk_d   = 1'b0;
    reload_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        nav_d   = DIR_R;
        pend_d  = DIR_R;
        score_d = '0;
        if (any_dir) begin
          state_d  = S_PLAY;
          reload_d = 1'b1;
        end
      end

      S_PLAY: begin
        if (tick) begin
          gclk_d = 1'b1;
          cnt_d  = '0;
          nav_d  = pend_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (dir_vld) begin
          pend_d = dir_sel;
        end
        if (p_t) begin
          score_d  = score_inc;
          reload_d = 1'b1;
        end
        if (p_t && (score_inc == 4'(WIN_SCORE))) begin
          state_d = S_WIN;
        end
`ifdef SNAKE_PAUSE_EN
        else if (p_c) begin
          state_d = S_PAUSE;
        end
`endif
      end

      S_WIN: begin
        cnt_d = '0;
        if (any_dir) begin
          state_d = S_IDLE;
          score_d = '0;
          nav_d   = DIR_R;
          pend_d  = DIR_R;
        end
      end

      S_PAUSE: begin
`ifdef SNAKE_PAUSE_EN
        // counter and pending direction hold; only BTN_C matters
        if (p_c) begin
          state_d = S_PLAY;
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign MASTER_STATE     = state_q;
  assign NAVIGATION_STATE = nav_q;
  assign GAMECLOCK        = gclk_q;
  assign SCORE            = score_q;
  assign APPLE_RELOAD     = reload_q;

endmodule

// File: tb/tb_snake_game_master.sv
// tb_snake_game_master: directed table, hand sequences and random
// stimulus for snake_game_master, checked against a reference model.
module tb_snake_game_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bu = 1'b0;
  logic bd = 1'b0;
  logic bl = 1'b0;
  logic br = 1'b0;
  logic bc = 1'b0;
  logic tg = 1'b0;
  logic chk_en = 1'b0;

  logic [1:0] ms0, nav0, ms1, nav1;
  logic [3:0] sc0, sc1;
  logic       gc0, ar0, gc1, ar1;

  always #5 clk = ~clk;

  snake_game_master #(
    .BASE_PERIOD(20), .SPEEDUP_STEP(4),
    .MIN_PERIOD(8), .WIN_SCORE(3)
  ) dut (
    .CLK(clk), .RESET(rst_n),
    .BTN_U(bu), .BTN_D(bd), .BTN_L(bl),
    .BTN_R(br), .BTN_C(bc),
    .REACHED_TARGET(tg),
    .MASTER_STATE(ms0), .NAVIGATION_STATE(nav0),
    .GAMECLOCK(gc0), .SCORE(sc0),
    .APPLE_RELOAD(ar0)
  );

  snake_game_master #(
    .BASE_PERIOD(20), .SPEEDUP_STEP(4),
    .MIN_PERIOD(8), .WIN_SCORE(15)
  ) dut15 (
    .CLK(clk), .RESET(rst_n),
    .BTN_U(bu), .BTN_D(bd), .BTN_L(bl),
    .BTN_R(br), .BTN_C(bc),
    .REACHED_TARGET(tg),
    .MASTER_STATE(ms1), .NAVIGATION_STATE(nav1),
    .GAMECLOCK(gc1), .SCORE(sc1),
    .APPLE_RELOAD(ar1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------
  // Reference model: game rules in plain integers.
  // Headings: 0=right 1=down 2=up 3=left. A press is seen two
  // samples after a 0->1 change in the sampled input level.
  // ------------------------------------------------------------
  typedef struct {
    int st;
    int dir;
    int pend;
    int score;
    int cnt;
    int g;
    int r;
  } mdl_t;

  mdl_t m0, m1;
  logic [5:0] h1 = '0, h2 = '0, h3 = '0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.dir = 0; m.pend = 0; m.score = 0;
    m.cnt = 0; m.g = 0; m.r = 0;
    return m;
  endfunction

  // pr bits: [5]=C [4]=U [3]=D [2]=L [1]=R [0]=target
  function automatic mdl_t mstep(mdl_t m, int win, logic [5:0] pr);
    mdl_t n;
    int   p;
    int   want;
    bit   anyd;
    n = m;
    n.g = 0;
    n.r = 0;
    anyd = (pr[4:1] != 4'b0000);
    if (m.st == 0) begin
      n.cnt = 0; n.dir = 0; n.pend = 0; n.score = 0;
      if (anyd) begin n.st = 1; n.r = 1; end
    end else if (m.st == 1) begin
      p = 20 - 4 * m.score;
      if (p < 8) p = 8;
      want = -1;
      if (pr[4] && m.dir != 1) want = 2;
      else if (pr[3] && m.dir != 2) want = 1;
      else if (pr[2] && m.dir != 0) want = 3;
      else if (pr[1] && m.dir != 3) want = 0;
      if (m.cnt + 1 >= p) begin
        n.g = 1; n.cnt = 0; n.dir = m.pend;
      end else begin
        n.cnt = m.cnt + 1;
      end
      if (want >= 0) n.pend = want;
      if (pr[0]) begin
        n.score = (m.score < 15) ? m.score + 1 : 15;
        n.r = 1;
        if (n.score == win) n.st = 2;
      end
`ifdef SNAKE_PAUSE_EN
      if (n.st == 1 && pr[5]) n.st = 3;
`endif
    end else if (m.st == 2) begin
      if (anyd) begin
        n.st = 0; n.score = 0; n.dir = 0; n.pend = 0; n.cnt = 0;
      end
    end else begin
      if (pr[5]) n.st = 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset();
      m1 <= mreset();
      h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      m0 <= mstep(m0, 3, h2 & ~h3);
      m1 <= mstep(m1, 15, h2 & ~h3);
      h3 <= h2;
      h2 <= h1;
      h1 <= {bc, bu, bd, bl, br, tg};
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("m_state",  ms0,  m0.st);
      check("m_nav",    nav0, m0.dir);
      check("m_score",  sc0,  m0.score);
      check("m_gclk",   gc0,  m0.g);
      check("m_reload", ar0,  m0.r);
      check("m15_state",  ms1,  m1.st);
      check("m15_nav",    nav1, m1.dir);
      check("m15_score",  sc1,  m1.score);
      check("m15_gclk",   gc1,  m1.g);
      check("m15_reload", ar1,  m1.r);
    end
  end

  // ------------------------------------------------------------
  // Helpers
  // ------------------------------------------------------------
  task automatic drive(input logic [4:0] b, input logic t);
    {bc, bu, bd, bl, br} = b;
    tg = t;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic gc_of(input int sel);
    return (sel != 0) ? gc1 : gc0;
  endfunction

  task automatic wait_tick(input int sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gc_of(sel) && n <= 200);
  endtask

  task automatic measure(input int sel, input int exp, input string name);
    int n;
    wait_tick(sel, n);
    check({name, "_sync"}, int'(n <= 200), 1);
    wait_tick(sel, n);
    check(name, n, exp);
  endtask

  task automatic count_ticks(input int sel, input int cyc, output int k);
    k = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (gc_of(sel)) k++;
    end
  endtask

  task automatic catch_apple();
    drive(5'b00000, 1'b1);
    cycles(6);
    drive(5'b00000, 1'b0);
    cycles(3);
  endtask

  task automatic tap(input logic [4:0] b);
    drive(b, 1'b0);
    cycles(4);
    drive(5'b00000, 1'b0);
    cycles(2);
  endtask

  // ------------------------------------------------------------
  // Directed table: {buttons C,U,D,L,R, target, cycles, expected}
  // ------------------------------------------------------------
  typedef struct {
    logic [4:0] btn;
    logic       tgt;
    int         cyc;
    int         st;
    int         nav;
    int         sc;
    int         rel;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [1:0] last;

    tbl[0]  = '{5'b00000, 1'b0,  2, 0, 0, 0, 0};
    tbl[1]  = '{5'b00001, 1'b0,  3, 1, 0, 0, 1};
    tbl[2]  = '{5'b00000, 1'b0,  1, 1, 0, 0, 0};
    tbl[3]  = '{5'b00010, 1'b0,  3, 1, 0, 0, 0};
    tbl[4]  = '{5'b00000, 1'b0, 40, 1, 0, 0, 0};
    tbl[5]  = '{5'b00100, 1'b0, 25, 1, 1, 0, 0};
    tbl[6]  = '{5'b00000, 1'b0,  2, 1, 1, 0, 0};
    tbl[7]  = '{5'b01010, 1'b0, 25, 1, 3, 0, 0};
    tbl[8]  = '{5'b00000, 1'b0,  2, 1, 3, 0, 0};
    tbl[9]  = '{5'b00000, 1'b1, 50, 1, 3, 1, 0};
    tbl[10] = '{5'b00000, 1'b0,  5, 1, 3, 1, 0};
    tbl[11] = '{5'b00000, 1'b1,  5, 1, 3, 2, 0};
    tbl[12] = '{5'b00000, 1'b0,  5, 1, 3, 2, 0};
    tbl[13] = '{5'b00000, 1'b1,  5, 2, 3, 3, 0};
    tbl[14] = '{5'b00000, 1'b0, 30, 2, 3, 3, 0};
    tbl[15] = '{5'b01000, 1'b0,  3, 0, 0, 0, 0};
    tbl[16] = '{5'b00000, 1'b0,  3, 0, 0, 0, 0};

    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i].btn, tbl[i].tgt);
      repeat (tbl[i].cyc) @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d_state", i), ms0, tbl[i].st);
      check($sformatf("tbl%0d_nav", i), nav0, tbl[i].nav);
      check($sformatf("tbl%0d_score", i), sc0, tbl[i].sc);
      check($sformatf("tbl%0d_reload", i), ar0, tbl[i].rel);
    end

    // turn lands exactly on the tick
    @(negedge clk);
    tap(5'b00001);
    check("start_state", ms0, 1);
    wait_tick(0, n);
    drive(5'b00100, 1'b0);
    cycles(4);
    drive(5'b00000, 1'b0);
    last = nav0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gc0) break;
      last = nav0;
    end
    check("nav_before_tick", last, 0);
    check("nav_at_tick", nav0, 1);

    // speed-up and floor
    measure(0, 20, "period_s0");
    catch_apple();
    check("score_1", sc0, 1);
    measure(0, 16, "period_s1");
    check("score15_4", sc1, 4);
    measure(1, 8, "floor_s4");
    catch_apple();
    check("score_2", sc0, 2);
    measure(0, 12, "period_s2");
    catch_apple();
    check("win_state", ms0, 2);
    check("win_score", sc0, 3);
    count_ticks(0, 60, k);
    check("win_no_tick", k, 0);
    tap(5'b01000);
    check("exit_state", ms0, 0);
    check("exit_score", sc0, 0);
    check("exit_nav", nav0, 0);

    // async reset between edges
    tap(5'b00001);
    cycles(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", ms0, 0);
    check("rst_nav", nav0, 0);
    check("rst_gclk", gc0, 0);
    check("rst_score", sc0, 0);
    check("rst_reload", ar0, 0);
    check("rst15_state", ms1, 0);
    check("rst15_score", sc1, 0);
    check("rst15_nav", nav1, 0);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

`ifdef SNAKE_PAUSE_EN
    tap(5'b00001);
    wait_tick(0, n);
    cycles(5);
    tap(5'b10000);
    check("pause_state", ms0, 3);
    count_ticks(0, 40, k);
    check("pause_no_tick", k, 0);
    tap(5'b10000);
    check("resume_state", ms0, 1);
    wait_tick(0, n);
    check("resume_tick", int'(n <= 200), 1);
`else
    tap(5'b00001);
    tap(5'b10000);
    check("c_ignored", ms0, 1);
    check("c_ignored15", ms1, 1);
`endif

    // random play against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) bu = ~bu;
      if ($urandom_range(0, 15) == 0) bd = ~bd;
      if ($urandom_range(0, 15) == 0) bl = ~bl;
      if ($urandom_range(0, 15) == 0) br = ~br;
      if ($urandom_range(0, 39) == 0) bc = ~bc;
      if ($urandom_range(0, 24) == 0) tg = ~tg;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
